// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Purpose:
//   Sequences control-flow changes for the 16-bit pipeline. BEQ/JAL/JLR/JRI
//   are resolved while the instruction sits in ID. A taken branch or jump
//   produces a one-cycle redirect pulse to the PC unit together with the
//   target address. JAL/JLR also produce a one-cycle link-register write.
//   The IF/ID register is squashed for the redirect cycle plus FLUSH_CYCLES
//   further unstalled cycles. Saturating counters track resolved and taken
//   control-flow instructions.
//
// Parameters:
//   DATA_W        datapath / PC width
//   FLUSH_CYCLES  extra squash cycles after the redirect cycle (0..7)
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   synchronous reset, active-low
//   stall          in   hazard stall; ID contents held while high
//   valid_id       in   ID-stage instruction valid
//   opcode         in   ID opcode (1000 BEQ, 1001 JAL, 1010 JLR, 1011 JRI)
//   read_data0     in   regA value
//   read_data1     in   regB value
//   pc_id          in   PC of the ID instruction
//   imm_id         in   sign-extended immediate
//   redirect       out  one-cycle pulse: PC unit loads redirect_pc
//   redirect_pc    out  branch/jump target, valid while redirect=1
//   link_wr        out  one-cycle link write pulse for JAL/JLR
//   link_data      out  pc_id+1 of the jump, valid while link_wr=1
//   ifid_valid_in  out  0 squashes IF/ID, 1 is normal flow
//   busy           out  controller is not idle
//   br_cnt         out  control-flow instructions resolved (saturating)
//   taken_cnt      out  resolved instructions that redirected (saturating)
// ---------------------------------------------------------------------------
module branch_redirect_ctrl #(
  parameter int DATA_W       = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              valid_id,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] read_data0,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] pc_id,
  input  logic [DATA_W-1:0] imm_id,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              link_wr,
  output logic [DATA_W-1:0] link_data,
  output logic              ifid_valid_in,
  output logic              busy,
  output logic [15:0]       br_cnt,
  output logic [15:0]       taken_cnt
);

  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_JAL = 4'b1001;
  localparam logic [3:0] OP_JLR = 4'b1010;
  localparam logic [3:0] OP_JRI = 4'b1011;

  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);
  localparam logic [2:0]        FLUSH_LD = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REDIR = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // Saturating 16-bit increment: counters stick at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            r_state;
  logic [2:0]        r_flush_cnt;
  logic              r_redirect;
  logic [DATA_W-1:0] r_redirect_pc;
  logic              r_link_wr;
  logic [DATA_W-1:0] r_link_data;
  logic              r_ifid_valid;
  logic              r_busy;
  logic [15:0]       r_br_cnt;
  logic [15:0]       r_taken_cnt;

  logic              w_is_br;
  logic              w_taken;
  logic              w_is_link;
  logic [DATA_W-1:0] w_target;
  logic [DATA_W-1:0] w_link;
  logic              w_resolve;

  // ---- ID decode: classify the instruction and form its target ----
  // All adds wrap modulo 2^DATA_W; there is intentionally no overflow flag.
  always_comb begin
    w_is_br   = 1'b0;
    w_taken   = 1'b0;
    w_is_link = 1'b0;
    w_target  = '0;
    w_link    = pc_id + ONE;
    unique case (opcode)
      OP_BEQ: begin
        w_is_br  = 1'b1;
        w_taken  = (read_data0 == read_data1);
        w_target = pc_id + imm_id;
      end
      OP_JAL: begin
        w_is_br   = 1'b1;
        w_taken   = 1'b1;
        w_is_link = 1'b1;
        w_target  = pc_id + imm_id;
      end
      OP_JLR: begin
        w_is_br   = 1'b1;
        w_taken   = 1'b1;
        w_is_link = 1'b1;
        w_target  = read_data1;
      end
      OP_JRI: begin
        w_is_br  = 1'b1;
        w_taken  = 1'b1;
        w_target = read_data0 + imm_id;
      end
      default: ;
    endcase
  end

  // A stalled branch waits in ID and is resolved on the first unstalled
  // edge; anything seen outside IDLE is wrong-path and never resolved.
  assign w_resolve = (r_state == S_IDLE) && valid_id && !stall && w_is_br;

  // ---- Control FSM with registered outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_flush_cnt   <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_link_wr     <= 1'b0;
      r_link_data   <= '0;
      r_ifid_valid  <= 1'b1;
      r_busy        <= 1'b0;
      r_br_cnt      <= '0;
      r_taken_cnt   <= '0;
    end else begin
      // Pulses last exactly one cycle and are never held by stall.
      r_redirect <= 1'b0;
      r_link_wr  <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          r_ifid_valid <= 1'b1;
          r_busy       <= 1'b0;
          if (w_resolve) begin
            r_br_cnt <= sat_inc(r_br_cnt);
            if (w_taken) begin
              r_taken_cnt   <= sat_inc(r_taken_cnt);
              r_state       <= S_REDIR;
              r_busy        <= 1'b1;
              r_redirect    <= 1'b1;
              r_redirect_pc <= w_target;
              r_ifid_valid  <= 1'b0;
              if (w_is_link) begin
                r_link_wr   <= 1'b1;
                r_link_data <= w_link;
              end
            end
          end
        end

        S_REDIR: begin
          if (FLUSH_CYCLES > 0) begin
            r_state      <= S_FLUSH;
            r_flush_cnt  <= FLUSH_LD;
            r_ifid_valid <= 1'b0;
            r_busy       <= 1'b1;
          end else begin
            r_state      <= S_IDLE;
            r_ifid_valid <= 1'b1;
            r_busy       <= 1'b0;
          end
        end

        S_FLUSH: begin
          // Squash window only advances on unstalled cycles.
          if (!stall) begin
            if (r_flush_cnt <= 3'd1) begin
              r_flush_cnt  <= '0;
              r_state      <= S_IDLE;
              r_ifid_valid <= 1'b1;
              r_busy       <= 1'b0;
            end else begin
              r_flush_cnt <= r_flush_cnt - 3'd1;
            end
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_flush_cnt  <= '0;
          r_ifid_valid <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign redirect      = r_redirect;
  assign redirect_pc   = r_redirect_pc;
  assign link_wr       = r_link_wr;
  assign link_data     = r_link_data;
  assign ifid_valid_in = r_ifid_valid;
  assign busy          = r_busy;
  assign br_cnt        = r_br_cnt;
  assign taken_cnt     = r_taken_cnt;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//
// Directed bench for branch_redirect_ctrl (DATA_W=16, FLUSH_CYCLES=1).
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// that same point, so every check observes the state left by the last edge.
// ---------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        valid_id;
  logic [3:0]  opcode;
  logic [15:0] read_data0;
  logic [15:0] read_data1;
  logic [15:0] pc_id;
  logic [15:0] imm_id;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        link_wr;
  logic [15:0] link_data;
  logic        ifid_valid_in;
  logic        busy;
  logic [15:0] br_cnt;
  logic [15:0] taken_cnt;

  int checks = 0;
  int errors = 0;

  branch_redirect_ctrl #(
    .DATA_W       (16),
    .FLUSH_CYCLES (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .valid_id      (valid_id),
    .opcode        (opcode),
    .read_data0    (read_data0),
    .read_data1    (read_data1),
    .pc_id         (pc_id),
    .imm_id        (imm_id),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .link_wr       (link_wr),
    .link_data     (link_data),
    .ifid_valid_in (ifid_valid_in),
    .busy          (busy),
    .br_cnt        (br_cnt),
    .taken_cnt     (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] op, input logic [15:0] r0,
                        input logic [15:0] r1, input logic [15:0] pc, input logic [15:0] imm);
    valid_id   = v;
    opcode     = op;
    read_data0 = r0;
    read_data1 = r1;
    pc_id      = pc;
    imm_id     = imm;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    set_id(1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Power-on reset
    step();
    step();
    chk("rst_redirect", redirect, 0);
    chk("rst_ifid", ifid_valid_in, 1);
    chk("rst_busy", busy, 0);
    chk("rst_br", br_cnt, 0);
    chk("rst_taken", taken_cnt, 0);
    chk("rst_rpc", redirect_pc, 0);
    rst_n = 1'b1;

    // BEQ taken
    set_id(1'b1, 4'b1000, 16'h1234, 16'h1234, 16'h0010, 16'h0005);
    step();
    chk("beq_redirect", redirect, 1);
    chk("beq_rpc", redirect_pc, 16'h0015);
    chk("beq_link_wr", link_wr, 0);
    chk("beq_ifid_c1", ifid_valid_in, 0);
    chk("beq_busy", busy, 1);
    chk("beq_br", br_cnt, 1);
    chk("beq_taken", taken_cnt, 1);
    valid_id = 1'b0;
    step();
    chk("beq_redirect_drop", redirect, 0);
    chk("beq_ifid_c2", ifid_valid_in, 0);
    step();
    chk("beq_ifid_c3", ifid_valid_in, 1);
    chk("beq_idle", busy, 0);
    chk("beq_rpc_hold", redirect_pc, 16'h0015);

    // Reset asserted mid-flush
    set_id(1'b1, 4'b1000, 16'h1234, 16'h1234, 16'h0010, 16'h0005);
    step();
    valid_id = 1'b0;
    step();
    chk("pre_rst_flush_busy", busy, 1);
    rst_n = 1'b0;
    step();
    step();
    chk("mrst_busy", busy, 0);
    chk("mrst_ifid", ifid_valid_in, 1);
    chk("mrst_redirect", redirect, 0);
    chk("mrst_br", br_cnt, 0);
    chk("mrst_taken", taken_cnt, 0);
    rst_n = 1'b1;

    // BEQ not taken
    set_id(1'b1, 4'b1000, 16'h0001, 16'h0002, 16'h0020, 16'h0007);
    step();
    chk("bnt_redirect", redirect, 0);
    chk("bnt_ifid", ifid_valid_in, 1);
    chk("bnt_br", br_cnt, 1);
    chk("bnt_taken", taken_cnt, 0);
    valid_id = 1'b0;
    step();
    chk("bnt_ifid2", ifid_valid_in, 1);

    // JAL with PC wrap
    set_id(1'b1, 4'b1001, 16'h0000, 16'h0000, 16'hFFFE, 16'h0003);
    step();
    chk("jal_redirect", redirect, 1);
    chk("jal_rpc", redirect_pc, 16'h0001);
    chk("jal_link_wr", link_wr, 1);
    chk("jal_link_data", link_data, 16'hFFFF);
    chk("jal_br", br_cnt, 2);
    chk("jal_taken", taken_cnt, 1);
    valid_id = 1'b0;
    step();
    chk("jal_link_drop", link_wr, 0);
    chk("jal_link_hold", link_data, 16'hFFFF);
    step();
    chk("jal_idle", busy, 0);

    // JLR
    set_id(1'b1, 4'b1010, 16'h5555, 16'h00AA, 16'h0200, 16'h0000);
    step();
    chk("jlr_rpc", redirect_pc, 16'h00AA);
    chk("jlr_link_wr", link_wr, 1);
    chk("jlr_link_data", link_data, 16'h0201);
    chk("jlr_br", br_cnt, 3);
    valid_id = 1'b0;
    step();
    step();
    chk("jlr_idle", ifid_valid_in, 1);

    // JRI held by stall, then stall inside FLUSH
    set_id(1'b1, 4'b1011, 16'h0100, 16'h0000, 16'h0300, 16'hFFFF);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("jri_stalled_redirect", redirect, 0);
      chk("jri_stalled_br", br_cnt, 3);
    end
    stall = 1'b0;
    step();
    chk("jri_redirect", redirect, 1);
    chk("jri_rpc", redirect_pc, 16'h00FF);
    chk("jri_link_wr", link_wr, 0);
    chk("jri_sq1", ifid_valid_in, 0);
    chk("jri_br", br_cnt, 4);
    chk("jri_taken", taken_cnt, 3);
    valid_id = 1'b0;
    step();
    chk("jri_sq2", ifid_valid_in, 0);
    stall = 1'b1;
    step();
    chk("jri_sq3", ifid_valid_in, 0);
    step();
    chk("jri_sq4", ifid_valid_in, 0);
    chk("jri_sq4_busy", busy, 1);
    stall = 1'b0;
    step();
    chk("jri_release", ifid_valid_in, 1);
    chk("jri_release_busy", busy, 0);

    // Wrong-path JAL during REDIR/FLUSH; stall in REDIR must not stretch
    set_id(1'b1, 4'b1000, 16'h0007, 16'h0007, 16'h0400, 16'h0010);
    step();
    chk("wp_redirect", redirect, 1);
    chk("wp_rpc", redirect_pc, 16'h0410);
    set_id(1'b1, 4'b1001, 16'h0000, 16'h0000, 16'h0040, 16'h0002);
    stall = 1'b1;
    step();
    chk("wp_no_stretch", redirect, 0);
    chk("wp_flush_ifid", ifid_valid_in, 0);
    stall = 1'b0;
    step();
    chk("wp_redirect_none", redirect, 0);
    chk("wp_link_none", link_wr, 0);
    chk("wp_br", br_cnt, 5);
    chk("wp_taken", taken_cnt, 4);
    chk("wp_ifid", ifid_valid_in, 1);
    chk("wp_rpc_hold", redirect_pc, 16'h0410);

    // Saturation: not-taken BEQs every cycle until br_cnt reaches 0xFFFF
    set_id(1'b1, 4'b1000, 16'h0001, 16'h0002, 16'h0000, 16'h0000);
    repeat (65530) @(posedge clk);
    #1;
    chk("sat_reach", br_cnt, 16'hFFFF);
    step();
    chk("sat_hold", br_cnt, 16'hFFFF);
    chk("sat_taken", taken_cnt, 4);
    set_id(1'b1, 4'b1000, 16'h0003, 16'h0003, 16'h0100, 16'h0001);
    step();
    chk("sat_hold_taken_br", br_cnt, 16'hFFFF);
    chk("sat_taken_inc", taken_cnt, 5);
    chk("sat_rpc", redirect_pc, 16'h0101);
    valid_id = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
